// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundles the fetch stage's control, instruction-memory and
//             IF/ID pipeline-register signals.
//  Modports : master - fetch stage side (drives imem request and IF/ID outputs)
//             slave  - environment side (drives hazard/branch controls, imem data)
//  Signals  : freeze, branch_taken, branch_addr[31:0]     (to fetch stage)
//             imem_read, imem_address[31:0]              (to instruction memory)
//             imem_data[31:0]                            (from instruction memory)
//             pc_out, instruction_out, valid_out         (IF/ID register)
//             fetch_count[31:0], stall_count[15:0]       (statistics)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_count;
    logic [15:0] stall_count;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_read, imem_address, pc_out, instruction_out, valid_out,
               fetch_count, stall_count
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_read, imem_address, pc_out, instruction_out, valid_out,
               fetch_count, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage. Holds the PC, requests instructions
//             from instruction memory (combinational read) and loads the
//             IF/ID pipeline register. Handles branch redirect/flush and
//             hazard freeze, and keeps fetch/stall statistics.
//  Ports    : clk  - clock, rising-edge active
//             rst  - asynchronous active-high reset
//             bus  - fetch_stage_if.master (see interface header)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_stage_if.master   bus
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] pc_out_q,    pc_out_d;
    logic [31:0] instr_q,     instr_d;
    logic        valid_q,     valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;   // wraps mod 2^32

    // Memory request comes straight from registered state so the address is
    // stable for the whole cycle and equals RESET_PC while rst is held.
    assign bus.imem_read    = (state_q != S_BOOT);
    assign bus.imem_address = {pc_q[31:2], 2'b00};

    assign bus.pc_out          = pc_out_q;
    assign bus.instruction_out = instr_q;
    assign bus.valid_out       = valid_q;
    assign bus.fetch_count     = fetch_cnt_q;
    assign bus.stall_count     = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            // One idle cycle lets instruction memory finish its own reset
            // load; controls are ignored here.
            S_BOOT: begin
                state_d = S_RUN;
            end

            S_RUN, S_STALL: begin
                // Branch wins over freeze: the wrong-path instruction must be
                // squashed even while the back end is stalled.
                if (bus.branch_taken) begin
                    pc_d     = {bus.branch_addr[31:2], 2'b00};
                    pc_out_d = 32'd0;
                    instr_d  = NOP_INSTR;
                    valid_d  = 1'b0;
                    state_d  = S_RUN;
                end else if (bus.freeze) begin
                    if (stall_cnt_q != 16'hFFFF) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end
                    state_d = S_STALL;
                end else begin
                    pc_d        = pc_plus4;
                    pc_out_d    = pc_plus4;
                    instr_d     = bus.imem_data;
                    valid_d     = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_RUN;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            pc_out_q    <= 32'd0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A reference model predicts
//             the post-edge outputs for each driven cycle; predictions are
//             queued and compared after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] C_NOP       = 32'hE000_0000;

    typedef struct packed {
        logic        imem_read;
        logic [31:0] imem_address;
        logic [31:0] pc_out;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] fcount;
        logic [15:0] scount;
    } exp_t;

    logic clk;
    logic rst;
    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, otherwise an
    // address-derived pattern so each fetch is distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hE3A0_0014;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_address);

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference model state (0 = boot, 1 = run, 2 = stall)
    int          m_state;
    logic [31:0] m_pc, m_pc_out, m_instr, m_fc;
    logic        m_valid;
    logic [15:0] m_sc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = C_RESET_PC; m_pc_out = 32'd0; m_instr = C_NOP;
        m_valid = 1'b0; m_fc = 32'd0; m_sc = 16'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},    {31'd0, bus.imem_read}, 32'd0);
        check({tag, "_addr"},  bus.imem_address, C_RESET_PC);
        check({tag, "_pcout"}, bus.pc_out, 32'd0);
        check({tag, "_instr"}, bus.instruction_out, C_NOP);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
        check({tag, "_fc"},    bus.fetch_count, 32'd0);
        check({tag, "_sc"},    {16'd0, bus.stall_count}, 32'd0);
    endtask

    // Drive one cycle of controls, predict the post-edge outputs, then
    // compare after the edge.
    task automatic step(input logic frz, input logic br, input logic [31:0] baddr);
        exp_t e;
        exp_t got;
        bus.freeze       = frz;
        bus.branch_taken = br;
        bus.branch_addr  = baddr;
        if (m_state == 0) begin
            m_state = 1;
        end else if (br) begin
            m_pc = {baddr[31:2], 2'b00}; m_pc_out = 32'd0; m_instr = C_NOP;
            m_valid = 1'b0; m_state = 1;
        end else if (frz) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            m_state = 2;
        end else begin
            m_instr = mem_word({m_pc[31:2], 2'b00});
            m_pc = m_pc + 32'd4; m_pc_out = m_pc; m_valid = 1'b1;
            m_fc = m_fc + 32'd1; m_state = 1;
        end
        e.imem_read    = (m_state != 0);
        e.imem_address = {m_pc[31:2], 2'b00};
        e.pc_out       = m_pc_out;
        e.instr        = m_instr;
        e.valid        = m_valid;
        e.fcount       = m_fc;
        e.scount       = m_sc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("imem_read", {31'd0, bus.imem_read}, {31'd0, got.imem_read});
        check("imem_addr", bus.imem_address, got.imem_address);
        check("pc_out",    bus.pc_out, got.pc_out);
        check("instr",     bus.instruction_out, got.instr);
        check("valid",     {31'd0, bus.valid_out}, {31'd0, got.valid});
        check("fetch_cnt", bus.fetch_count, got.fcount);
        check("stall_cnt", {16'd0, bus.stall_count}, {16'd0, got.scount});
    endtask

    initial begin
        bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'd0;
        rst = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("reset");
        // Controls asserted during reset must not matter.
        bus.freeze = 1'b1; bus.branch_taken = 1'b1; bus.branch_addr = 32'h40;
        @(posedge clk); #1;
        check_reset_outputs("reset_hold");
        bus.freeze = 1'b0; bus.branch_taken = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("boot_rd", {31'd0, bus.imem_read}, 32'd0);

        // BOOT edge with controls asserted: ignored.
        step(1'b1, 1'b1, 32'h100);
        check("first_addr", bus.imem_address, C_RESET_PC);
        step(1'b0, 1'b0, 32'd0);
        check("first_instr", bus.instruction_out, 32'hE3A0_0014);
        check("first_pcout", bus.pc_out, 32'd4);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        check("frz_addr", bus.imem_address, 32'd20);
        check("frz_sc",   {16'd0, bus.stall_count}, 32'd3);
        check("frz_fc",   bus.fetch_count, 32'd5);
        step(1'b0, 1'b0, 32'd0);
        check("resume_pcout", bus.pc_out, 32'd24);

        // Branch with freeze in the same cycle, from STALL.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_0083);
        check("br_addr", bus.imem_address, 32'h80);
        check("br_instr", bus.instruction_out, C_NOP);
        step(1'b0, 1'b0, 32'd0);

        // PC wrap.
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'd0);
        check("wrap_addr",  bus.imem_address, 32'd0);
        check("wrap_pcout", bus.pc_out, 32'd0);

        // Random mix of controls.
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 32'h3FF));

        // Stall counter saturation.
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 32'd0);
        check("sat_sc", {16'd0, bus.stall_count}, 32'h0000_FFFF);
        step(1'b0, 1'b0, 32'd0);

        // Asynchronous reset mid-STALL, checked before the next edge.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        bus.freeze = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'hE000_0000: bubble instruction (AND R0,R0,R0, cond AL) driven on flush/empty.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 freeze  input  1: hazard stall from hazard unit; hold PC and IF/ID register.
REQ-006 branch_taken  input  1: branch resolved taken; redirect PC, flush IF/ID.
REQ-007 branch_addr  input  32: branch target byte address.
REQ-008 imem_read  output  1: read enable to instruction memory.
REQ-009 imem_address  output  32: word-aligned fetch address to instruction memory.
REQ-010 imem_data  input  32: instruction word returned by instruction memory, same cycle as address.
REQ-011 pc_out  output  32: registered PC+4 of the instruction in IF/ID.
REQ-012 instruction_out  output  32: registered IF/ID instruction.
REQ-013 valid_out  output  1: IF/ID holds a real fetched instruction.
REQ-014 fetch_count  output  32: number of instructions accepted into IF/ID since reset.
REQ-015 stall_count  output  16: number of cycles spent in STALL since reset.

Function
REQ-016 State machine SHALL have states BOOT, RUN, STALL; rst forces BOOT.
REQ-017 BOOT: imem_read=0, PC and IF/ID held; next state RUN unconditionally (one cycle, lets memory finish its reset load).
REQ-018 RUN and STALL: imem_read=1; imem_address={pc[31:2],2'b00}; imem_data consumed combinationally, zero extra latency.
REQ-019 Priority at each edge in RUN/STALL: branch_taken > freeze > normal advance.
REQ-020 branch_taken=1: pc<=branch_addr with bits [1:0] forced to 0; IF/ID<= {pc_out=0, NOP_INSTR, valid=0}; counters unchanged; next state RUN, regardless of freeze.
REQ-021 freeze=1, branch_taken=0: pc, pc_out, instruction_out, valid_out, fetch_count held; stall_count+1 (saturating at 16'hFFFF); next state STALL.
REQ-022 Neither asserted: pc<=pc+4; IF/ID<= {pc+4, imem_data, valid=1}; fetch_count+1; next state RUN.
REQ-023 STALL exits to RUN on the first edge with freeze=0, performing the REQ-022 or REQ-020 action on that same edge.
REQ-024 PC arithmetic mod 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000; pc_out likewise wraps.
REQ-025 fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-026 Inputs freeze/branch_taken in BOOT SHALL be ignored.
REQ-027 All outputs except imem_address/imem_read SHALL be registered; imem_address derived from registered pc only.

Reset
REQ-028 Asserting rst at any time, including mid-stall or same cycle as branch_taken, SHALL immediately set: state BOOT, pc=RESET_PC, pc_out=0, instruction_out=NOP_INSTR, valid_out=0, fetch_count=0, stall_count=0, imem_read=0.
REQ-029 imem_address SHALL equal RESET_PC while rst is high.
REQ-030 First real fetch SHALL occur at address RESET_PC on the second rising edge after rst deasserts (first edge leaves BOOT).

Verification
REQ-031 Release reset, imem_data=32'hE3A0_0014 at addr 0 -> cycle 1 imem_read=0; after next edge instruction_out=32'hE3A0_0014, pc_out=4, valid_out=1, fetch_count=1.
REQ-032 Run 5 sequential fetches, then freeze=1 for 3 cycles -> pc_out/instruction_out frozen, imem_address constant 20, stall_count=3, fetch_count=5; release -> advance resumes at 20.
REQ-033 branch_taken=1, branch_addr=32'h0000_0083, with freeze=1 same cycle -> next imem_address=32'h80, instruction_out=32'hE000_0000, valid_out=0, fetch_count unchanged, state RUN.
REQ-034 Force pc to 32'hFFFF_FFFC via branch, then one advance -> imem_address=0, pc_out=0.
REQ-035 Assert rst asynchronously mid-STALL (between edges) -> all outputs take REQ-028 values before next clk edge.
